// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the default number of contended cycles before debug is forced in.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    localparam int MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational 2:1 selection of the data-memory port between the pipeline
// MEM stage and the debug requester.
module dmem_port_mux #(
    parameter int DBITS = 32
) (
    input  logic             sel_dbg,
    input  logic             pipe_valid,
    input  logic             pipe_wr,
    input  logic [DBITS-1:0] pipe_addr,
    input  logic [DBITS-1:0] pipe_wdata,
    input  logic             dbg_wr,
    input  logic [DBITS-1:0] dbg_addr,
    input  logic [DBITS-1:0] dbg_wdata,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata
);

    // Debug owns the port only in its grant cycle; otherwise the pipeline does.
    always_comb begin
        if (sel_dbg) begin
            mem_we    = dbg_wr;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_we    = pipe_valid & pipe_wr;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage has priority, the debug
// requester is guaranteed a slot after MAX_WAIT contended cycles, at the
// cost of a single-cycle pipeline stall.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DBITS     = 32,
    parameter int MAX_WAIT  = MAX_WAIT_DEFAULT,
    parameter int WAIT_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_valid,
    input  logic             pipe_wr,
    input  logic [DBITS-1:0] pipe_addr,
    input  logic [DBITS-1:0] pipe_wdata,
    output logic [DBITS-1:0] pipe_rdata,
    output logic             pipe_stall,
    input  logic             dbg_req,
    input  logic             dbg_wr,
    input  logic [DBITS-1:0] dbg_addr,
    input  logic [DBITS-1:0] dbg_wdata,
    output logic             dbg_ack,
    output logic [DBITS-1:0] dbg_rdata,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(MAX_WAIT);

    state_e               state_q, state_d;
    logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic [DBITS-1:0]     dbg_rdata_q;
    logic                 dbg_gnt;
    logic                 wait_at_max;
    logic                 mux_we;

    assign wait_at_max = (wait_cnt_q == WAIT_LIMIT);

    // Grant decision, next state and wait counter; reset suppresses any grant
    // so an access in flight during reset never touches memory.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dbg_gnt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dbg_gnt = ~reset & dbg_req & (~pipe_valid | wait_at_max);
                if (dbg_gnt) begin
                    state_d    = ST_ACK;
                    wait_cnt_d = '0;
                end else if (!dbg_req) begin
                    wait_cnt_d = '0;
                end else if (!wait_at_max) begin
                    // dbg_req without grant implies pipe_valid: a contended cycle
                    wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and debug read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (dbg_gnt) begin
                // Captured before the write lands, so writes return the old word.
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    dmem_port_mux #(
        .DBITS(DBITS)
    ) u_port_mux (
        .sel_dbg    (dbg_gnt),
        .pipe_valid (pipe_valid),
        .pipe_wr    (pipe_wr),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .mem_we     (mux_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

    assign mem_we     = mux_we & ~reset;
    assign pipe_rdata = mem_rdata;
    assign pipe_stall = dbg_gnt & pipe_valid;
    assign dbg_ack    = (state_q == ST_ACK);
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter for the single data-memory port, shared between the pipeline MEM stage and a debug/loader requester (memory inspection and program load over a host link). The pipeline has priority; a bounded-wait counter guarantees the debug requester a slot after MAX_WAIT contended cycles by stalling the pipeline for exactly one cycle. Sits between the MEM-stage latch outputs and the data memory. Its stall output ORs into the pipeline's existing stall and freezes the PC and all stage latches.

## Interface
- DBITS, 32, data and address width
- MAX_WAIT, 4, contended cycles before debug is forced in; 0 means debug always wins immediately
- WAIT_BITS, 3, wait-counter width; must hold MAX_WAIT
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pipe_valid  in  1  MEM stage holds a load or store this cycle
- pipe_wr  in  1  MEM access is a store
- pipe_addr  in  DBITS  MEM byte address (ALU result)
- pipe_wdata  in  DBITS  store data
- pipe_rdata  out  DBITS  load data to writeback mux
- pipe_stall  out  1  freeze pipeline this cycle
- dbg_req  in  1  debug access request, level, held until dbg_ack
- dbg_wr  in  1  debug access is a write
- dbg_addr  in  DBITS  debug byte address
- dbg_wdata  in  DBITS  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DBITS  registered debug read data, valid with dbg_ack and held until the next ack
- mem_we  out  1  data memory write enable
- mem_addr  out  DBITS  data memory address
- mem_wdata  out  DBITS  data memory write data
- mem_rdata  in  DBITS  data memory read data, combinational from mem_addr

## Operation
- Two states: IDLE and ACK.
- Grant rule, combinational, in IDLE only: dbg_gnt = dbg_req & (~pipe_valid | wait_cnt == MAX_WAIT).
- Port mux:
  - dbg_gnt=1: mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_we=dbg_wr.
  - Otherwise: mem_addr=pipe_addr, mem_wdata=pipe_wdata, mem_we=pipe_valid & pipe_wr.
- pipe_rdata = mem_rdata, unregistered.
- pipe_stall = dbg_gnt & pipe_valid. The stalled MEM access replays next cycle with identical inputs. A stalled store is not written in the grant cycle.
- On dbg_gnt: dbg_rdata <= mem_rdata. For writes, dbg_rdata holds the pre-write word. State moves to ACK.
- ACK: dbg_ack=1 for this one cycle; no grant is possible; next state is IDLE. The requester drops dbg_req in the ACK cycle or keeps it asserted to request a new access, which is evaluated from IDLE.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when in IDLE with dbg_req & pipe_valid & ~dbg_gnt.
  - Clears on dbg_gnt, or when dbg_req is low.
  - Holds in ACK.
- Same-address collision: the access granted first takes effect first. No merging or forwarding between requesters.

## Timing
- Reset values: state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0, pipe_stall=0, mem_we=0.
- Reset wins over every other event. Reset asserted during the grant cycle or in ACK aborts the access: no ack, and no retry.
- Uncontended debug access: grant in cycle N, dbg_ack in N+1. Minimum request-to-request period is 2 cycles.
- Worst-case debug latency from dbg_req rise to dbg_ack is MAX_WAIT+2 cycles.
- The pipeline is never stalled more than 1 cycle in any 2.
- pipe_stall, mem_* and pipe_rdata are combinational, with zero latency from inputs. No combinational path from dbg_req to dbg_ack.
- dbg_req dropped before grant: no access occurs and wait_cnt returns to 0 next cycle.

## Structure
- Shared package: state encoding (ST_IDLE, ST_ACK) and the MAX_WAIT default.
- Natural sub-module: dmem_port_mux, the combinational 2:1 selection of addr/wdata/we.
- Everything else stays in one module: FSM, wait counter and read-data register.

## Test plan
- Reset, with no requests: all outputs 0. Then pipe_valid=1, pipe_wr=1, pipe_addr=0x100, pipe_wdata=0xDEADBEEF -> mem_we=1 at addr 0x100, pipe_stall=0.
- dbg_req with dbg_wr=0, dbg_addr=0x200 and pipe_valid=0; memory holds 0x12345678 at 0x200 -> grant cycle N, dbg_ack in N+1 with dbg_rdata=0x12345678.
- dbg_req write held while pipe_valid=1 continuously, MAX_WAIT=4 -> 4 cycles with pipeline owning the port, grant on cycle 5 with pipe_stall=1 for exactly that cycle, then dbg_ack.
- dbg_req held high through ACK with pipe_valid=1 -> the second grant is not earlier than MAX_WAIT+1 cycles after the first, and pipe_stall is never high on consecutive cycles.
- dbg_req dropped after 2 contended cycles -> wait_cnt back to 0; a new request waits the full MAX_WAIT again.
- Reset asserted in the grant cycle -> no dbg_ack; all outputs at reset values next cycle.
